md_frame_decoder: RTL and testbench
===================================

MD_FRAME_DECODER -- requirements
Module: md_frame_decoder

Interface
REQ-001 SHALL have parameter UDP_DST_PORT, default 16'h04D2, meaning the accepted UDP destination port as a byte-order value: the first byte is 0x04 and the second is 0xD2.
REQ-002 SHALL have parameter MAGIC, default 16'hAA55, meaning the 2-byte market-data header that follows the UDP checksum: the first byte is 0xAA and the second is 0x55.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port s_axis_tdata, input, 32 bits: the Ethernet frame stream. Frame byte n is in lane (n mod 4), at bits [8*lane+7 : 8*lane].
REQ-006 SHALL have ports s_axis_tvalid and s_axis_tlast, inputs, 1 bit each: AXI-Stream valid and last.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: AXI-Stream ready.
REQ-008 SHALL have ports tick_price and tick_qty, outputs, 32 bits each: the decoded price and quantity.
REQ-009 SHALL have port tick_is_buy, output, 1 bit: 1 for a buy, 0 for a sell.
REQ-010 SHALL have port tick_valid, output, 1 bit: a one-cycle strobe marking a new tick.
REQ-011 SHALL have ports pkt_ok_count and pkt_drop_count, outputs, 16 bits each: the accepted-frame and dropped-frame counters.

Function
REQ-012 SHALL accept a beat only when s_axis_tvalid=1 and s_axis_tready=1. The word index (0..13) SHALL advance only on an accepted beat. Idle cycles between beats SHALL have no effect.
REQ-013 SHALL drive s_axis_tready=1 in every cycle after reset; the block never backpressures.
REQ-014 SHALL have the FSM states IDLE, HDR, PAYLOAD and DROP.
REQ-015 SHALL, in IDLE, treat the next accepted beat as word 0 and go to HDR. If that beat has tlast=1, the frame SHALL be counted as a drop and the FSM SHALL stay in IDLE.
REQ-016 SHALL, in HDR (words 1..10), check every one of the following:
- word 3: lane0=0x08, lane1=0x00;
- word 5: lane3=0x11;
- word 9: lane0 = UDP_DST_PORT[15:8], lane1 = UDP_DST_PORT[7:0];
- word 10: lane2 = MAGIC[15:8], lane3 = MAGIC[7:0].
REQ-017 SHALL go HDR->PAYLOAD after word 10 is accepted with all checks passing.
REQ-018 SHALL, in PAYLOAD (words 11..13), check word 11 lane0=0x09 and capture the payload bytes:
- p0..p2 from word 11 lanes 1..3;
- p3..p6 from word 12 lanes 0..3;
- p7, p8 from word 13 lanes 0..1;
- the checksum byte from word 13 lane2.
REQ-019 SHALL form the price as {p0,p1,p2,p3} and the quantity as {p4,p5,p6,p7} (big-endian).
REQ-020 SHALL decode the side byte p8: 0x42 gives is_buy=1, 0x53 gives is_buy=0, and any other value is a drop.
REQ-021 SHALL accept the frame only if the XOR of p0..p8 equals the checksum byte.
REQ-022 SHALL require tlast=1 exactly on word 13. On a frame accepted at word 13, the block SHALL:
- pulse tick_valid for exactly one cycle, in the cycle after word 13 is accepted (latency 1);
- update tick_price, tick_qty and tick_is_buy in that same cycle;
- increment pkt_ok_count;
- return to IDLE.
REQ-023 SHALL hold tick_price, tick_qty and tick_is_buy at their last value until the next accepted frame.
REQ-024 SHALL handle a failed check on word 13 when tlast=1 by incrementing pkt_drop_count and going to IDLE.
REQ-025 SHALL handle any other failed check, and word 13 arriving with tlast=0, by going to DROP.
REQ-026 SHALL, in DROP, discard beats until a beat with tlast=1 is accepted, then increment pkt_drop_count once and go to IDLE.
REQ-027 SHALL treat tlast=1 before word 13 as a runt frame: increment pkt_drop_count once and go to IDLE in the next cycle.
REQ-028 SHALL saturate both counters at 16'hFFFF; they never wrap.
REQ-029 SHALL make back-to-back frames work with zero idle cycles: the word 0 that immediately follows a tlast beat SHALL be decoded as a new frame.

Reset
REQ-030 SHALL, while rst_n=0, put the FSM in IDLE and clear the word index and all internal payload registers.
REQ-031 SHALL, while rst_n=0, drive every output to 0: s_axis_tready, tick_price, tick_qty, tick_is_buy, tick_valid and both counters.
REQ-032 SHALL treat the first accepted beat after rst_n deasserts mid-frame as word 0. That partial frame SHALL then fail the checks and be dropped at its tlast.

Verification
REQ-033 SHALL pass this directed scenario: valid buy frame, price=100, qty=50, side 0x42, correct checksum -> one cycle after word 13, tick_valid=1 for 1 cycle, tick_price=100, tick_qty=50, tick_is_buy=1, pkt_ok_count=1.
REQ-034 SHALL pass this directed scenario: sell frame, price=108, qty=30, with 3 tvalid=0 gaps inside words 4..12 -> tick_price=108, tick_qty=30, tick_is_buy=0, latency unchanged after the last beat.
REQ-035 SHALL pass this directed scenario: frame with its checksum XORed with 0x01 -> no tick_valid, pkt_drop_count increments by 1, tick outputs keep their prior values.
REQ-036 SHALL pass these directed scenarios, each as its own frame -> no tick and pkt_drop_count=3 afterwards:
- destination port 0x04D3;
- side byte 0x58;
- protocol 0x06.
REQ-037 SHALL pass this directed scenario: runt frame with tlast on word 9, immediately followed with zero gap by a valid buy frame, price=105, qty=75 -> drop_count +1, then one tick with price=105, qty=75.
REQ-038 SHALL pass this directed scenario: rst_n pulsed low during word 6, then a valid frame, price=110, qty=25, side 0x53 -> all outputs 0 during reset; afterwards the remainder of the interrupted frame is dropped, then one tick with price=110, qty=25, tick_is_buy=0.

Source files
------------

// File: rtl/md_frame_decoder.sv
// Purpose: decode UDP market-data ticks from a 32-bit Ethernet AXI-Stream and count ok/dropped frames.
// Latency: tick_valid and the tick fields update 1 cycle after word 13 of an accepted frame.
// Backpressure: none -- s_axis_tready stays high in every cycle after reset.
module md_frame_decoder #(
  parameter logic [15:0] UDP_DST_PORT = 16'h04D2,
  parameter logic [15:0] MAGIC        = 16'hAA55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] tick_price,
  output logic [31:0] tick_qty,
  output logic        tick_is_buy,
  output logic        tick_valid,
  output logic [15:0] pkt_ok_count,
  output logic [15:0] pkt_drop_count
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state;
  logic [3:0]  word_idx;   // index of the word the next accepted beat represents
  logic [55:0] pay_q;      // p0..p6, p0 in the top byte
  logic        beat;
  logic [7:0]  b0, b1, b2, b3;
  logic        hdr_ok;
  logic [7:0]  pay_xor;
  logic        side_ok;
  logic        frame_ok;

  assign beat = s_axis_tvalid & s_axis_tready;
  assign b0   = s_axis_tdata[7:0];
  assign b1   = s_axis_tdata[15:8];
  assign b2   = s_axis_tdata[23:16];
  assign b3   = s_axis_tdata[31:24];

  // Header field check for whichever header word is currently on the bus.
  always_comb begin
    hdr_ok = 1'b1;
    case (word_idx)
      4'd3:    hdr_ok = (b0 == 8'h08) && (b1 == 8'h00);
      4'd5:    hdr_ok = (b3 == 8'h11);
      4'd9:    hdr_ok = (b0 == UDP_DST_PORT[15:8]) && (b1 == UDP_DST_PORT[7:0]);
      4'd10:   hdr_ok = (b2 == MAGIC[15:8]) && (b3 == MAGIC[7:0]);
      default: hdr_ok = 1'b1;
    endcase
  end

  // Payload checksum: stored p0..p6 folded with the live p7 and p8 of word 13.
  always_comb begin
    pay_xor = b0 ^ b1;
    for (int i = 0; i < 7; i++) begin
      pay_xor = pay_xor ^ pay_q[8*i +: 8];
    end
    side_ok  = (b1 == 8'h42) || (b1 == 8'h53);
    frame_ok = side_ok && (pay_xor == b2);
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Frame FSM: walks the word index, captures the payload and owns every output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      word_idx       <= 4'd0;
      pay_q          <= '0;
      s_axis_tready  <= 1'b0;
      tick_price     <= '0;
      tick_qty       <= '0;
      tick_is_buy    <= 1'b0;
      tick_valid     <= 1'b0;
      pkt_ok_count   <= '0;
      pkt_drop_count <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      tick_valid    <= 1'b0;
      if (beat) begin
        case (state)
          IDLE: begin
            // This beat is word 0; a single-beat frame is a runt.
            if (s_axis_tlast) begin
              pkt_drop_count <= sat_inc(pkt_drop_count);
            end else begin
              state    <= HDR;
              word_idx <= 4'd1;
            end
          end
          HDR: begin
            if (s_axis_tlast) begin
              pkt_drop_count <= sat_inc(pkt_drop_count);
              state          <= IDLE;
              word_idx       <= 4'd0;
            end else if (!hdr_ok) begin
              state <= DROP;
            end else begin
              word_idx <= word_idx + 4'd1;
              if (word_idx == 4'd10) state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (word_idx == 4'd11) pay_q[55:32] <= {b1, b2, b3};
            if (word_idx == 4'd12) pay_q[31:0]  <= {b0, b1, b2, b3};
            if (word_idx == 4'd13) begin
              if (s_axis_tlast) begin
                if (frame_ok) begin
                  tick_valid   <= 1'b1;
                  tick_price   <= pay_q[55:24];
                  tick_qty     <= {pay_q[23:0], b0};
                  tick_is_buy  <= (b1 == 8'h42);
                  pkt_ok_count <= sat_inc(pkt_ok_count);
                end else begin
                  pkt_drop_count <= sat_inc(pkt_drop_count);
                end
                state    <= IDLE;
                word_idx <= 4'd0;
              end else begin
                // Frame runs past its fixed length: discard the tail.
                state <= DROP;
              end
            end else if (s_axis_tlast) begin
              pkt_drop_count <= sat_inc(pkt_drop_count);
              state          <= IDLE;
              word_idx       <= 4'd0;
            end else if ((word_idx == 4'd11) && (b0 != 8'h09)) begin
              state <= DROP;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
          DROP: begin
            if (s_axis_tlast) begin
              pkt_drop_count <= sat_inc(pkt_drop_count);
              state          <= IDLE;
              word_idx       <= 4'd0;
            end
          end
          default: begin
            state    <= IDLE;
            word_idx <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_frame_decoder.sv
// Purpose: self-checking bench for md_frame_decoder (directed table, corner sequences, random frames).
// Latency: expects tick outputs in the cycle after word 13 is accepted.
// Backpressure: waits (bounded) for s_axis_tready before each beat.
module tb_md_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] tick_price;
  logic [31:0] tick_qty;
  logic        tick_is_buy;
  logic        tick_valid;
  logic [15:0] pkt_ok_count;
  logic [15:0] pkt_drop_count;

  always #5 clk = ~clk;

  md_frame_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .tick_price     (tick_price),
    .tick_qty       (tick_qty),
    .tick_is_buy    (tick_is_buy),
    .tick_valid     (tick_valid),
    .pkt_ok_count   (pkt_ok_count),
    .pkt_drop_count (pkt_drop_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Frame image as a flat byte array: byte n travels in word n/4, lane n%4.
  logic [7:0]  fb [0:63];

  // Reference model state.
  int          exp_ok = 0;
  int          exp_drop = 0;
  logic [31:0] last_price = '0;
  logic [31:0] last_qty = '0;
  logic        last_buy = 1'b0;
  logic [64:0] exp_q [$];

  typedef struct {
    logic [31:0] price;
    logic [31:0] qty;
    logic [7:0]  side;
    int          bad_idx;
    logic [7:0]  bad_val;
    logic [7:0]  cs_flip;
    int          nw;
    int          gap;
    logic        exp_tick;
    logic [31:0] exp_price;
    logic [31:0] exp_qty;
    logic        exp_buy;
    int          exp_okc;
    int          exp_dropc;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic build_frame(input logic [31:0] price, input logic [31:0] qty, input logic [7:0] side,
                             input int bad_idx, input logic [7:0] bad_val, input logic [7:0] cs_flip);
    logic [7:0] cs;
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    fb[12] = 8'h08; fb[13] = 8'h00;           // ethertype IPv4
    fb[23] = 8'h11;                           // IP protocol UDP
    fb[36] = 8'h04; fb[37] = 8'hD2;           // UDP destination port
    fb[42] = 8'hAA; fb[43] = 8'h55;           // market-data magic
    fb[44] = 8'h09;                           // message type
    {fb[45], fb[46], fb[47], fb[48]} = price;
    {fb[49], fb[50], fb[51], fb[52]} = qty;
    fb[53] = side;
    if (bad_idx >= 0) fb[bad_idx] = bad_val;
    cs = 8'h00;
    for (int i = 45; i <= 53; i++) cs = cs ^ fb[i];
    fb[54] = cs ^ cs_flip;
  endtask

  // Decide a frame's fate from its byte image and length alone.
  task automatic model_frame(input int nw);
    logic [7:0] x;
    logic       ok;
    x = 8'h00;
    for (int i = 45; i <= 53; i++) x = x ^ fb[i];
    ok = (nw == 14) && (fb[12] == 8'h08) && (fb[13] == 8'h00) && (fb[23] == 8'h11) &&
         (fb[36] == 8'h04) && (fb[37] == 8'hD2) && (fb[42] == 8'hAA) && (fb[43] == 8'h55) &&
         (fb[44] == 8'h09) && ((fb[53] == 8'h42) || (fb[53] == 8'h53)) && (x == fb[54]);
    if (ok) begin
      if (exp_ok < 65535) exp_ok++;
      last_price = {fb[45], fb[46], fb[47], fb[48]};
      last_qty   = {fb[49], fb[50], fb[51], fb[52]};
      last_buy   = (fb[53] == 8'h42);
      exp_q.push_back({last_buy, last_price, last_qty});
    end else begin
      if (exp_drop < 65535) exp_drop++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    int g;
    g = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (s_axis_tready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tready_timeout: ready %0b, required 1", s_axis_tready);
    end
  endtask

  task automatic send_word(input int w, input logic last);
    beat({fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]}, last);
  endtask

  // gap: 0 none, 1 three idle cycles inside words 4..12, 2 random idle cycles
  task automatic send_frame(input int nw, input int gap);
    model_frame(nw);
    for (int w = 0; w < nw; w++) begin
      if (gap == 1 && (w == 4 || w == 8 || w == 12)) idle(1);
      else if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_word(w, w == nw - 1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_price"},  tick_price, 0);
    check({tag, "_qty"},    tick_qty, 0);
    check({tag, "_buy"},    tick_is_buy, 0);
    check({tag, "_valid"},  tick_valid, 0);
    check({tag, "_ok"},     pkt_ok_count, 0);
    check({tag, "_drop"},   pkt_drop_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [64:0] e;
    int          bad_list [9];
    int          nw;
    logic [7:0]  side;
    int          bidx;

    bad_list = '{12, 13, 23, 36, 37, 42, 43, 44, 53};

    //                price          qty            side   bad  val    flip   nw  gap tick  exp_price      exp_qty        buy  ok drop
    vecs[0]  = '{32'd100,       32'd50,        8'h42, -1, 8'h00, 8'h00, 14, 0, 1'b1, 32'd100,       32'd50,        1'b1, 1, 0};
    vecs[1]  = '{32'd108,       32'd30,        8'h53, -1, 8'h00, 8'h00, 14, 1, 1'b1, 32'd108,       32'd30,        1'b0, 2, 0};
    vecs[2]  = '{32'd200,       32'd7,         8'h42, -1, 8'h00, 8'h01, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 1};
    vecs[3]  = '{32'd300,       32'd9,         8'h42, 37, 8'hD3, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 2};
    vecs[4]  = '{32'd300,       32'd9,         8'h58, -1, 8'h00, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 3};
    vecs[5]  = '{32'd300,       32'd9,         8'h42, 23, 8'h06, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 4};
    vecs[6]  = '{32'd300,       32'd9,         8'h42, 43, 8'h56, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 5};
    vecs[7]  = '{32'd300,       32'd9,         8'h42, 12, 8'h86, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 6};
    vecs[8]  = '{32'd300,       32'd9,         8'h42, 44, 8'h0A, 8'h00, 14, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 7};
    vecs[9]  = '{32'd300,       32'd9,         8'h42, -1, 8'h00, 8'h00, 15, 0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 8};
    vecs[10] = '{32'd300,       32'd9,         8'h42, -1, 8'h00, 8'h00, 1,  0, 1'b0, 32'd108,       32'd30,        1'b0, 2, 9};
    vecs[11] = '{32'hDEADBEEF,  32'h12345678,  8'h53, -1, 8'h00, 8'h00, 14, 0, 1'b1, 32'hDEADBEEF,  32'h12345678,  1'b0, 3, 9};
    vecs[12] = '{32'hFFFFFFFF,  32'h00000000,  8'h42, -1, 8'h00, 8'h00, 14, 2, 1'b1, 32'hFFFFFFFF,  32'h00000000,  1'b1, 4, 9};

    // Every tick the DUT emits must match the next one the model predicted.
    fork
      forever begin
        @(negedge clk);
        if (tick_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tick", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("tick_fields", {tick_is_buy, tick_price, tick_qty}, e);
          end
        end
      end
    join_none

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    idle(2);
    check("tready_after_reset", s_axis_tready, 1);

    // Directed frame table.
    for (int i = 0; i < 13; i++) begin
      build_frame(vecs[i].price, vecs[i].qty, vecs[i].side, vecs[i].bad_idx, vecs[i].bad_val, vecs[i].cs_flip);
      send_frame(vecs[i].nw, vecs[i].gap);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      check($sformatf("vec%0d_tick_valid", i), tick_valid, vecs[i].exp_tick);
      check($sformatf("vec%0d_price", i), tick_price, vecs[i].exp_price);
      check($sformatf("vec%0d_qty", i), tick_qty, vecs[i].exp_qty);
      check($sformatf("vec%0d_is_buy", i), tick_is_buy, vecs[i].exp_buy);
      @(negedge clk);
      check($sformatf("vec%0d_tick_one_cycle", i), tick_valid, 0);
      idle(2);
      check($sformatf("vec%0d_ok_count", i), pkt_ok_count, vecs[i].exp_okc);
      check($sformatf("vec%0d_drop_count", i), pkt_drop_count, vecs[i].exp_dropc);
    end

    // Runt ending on word 9, then a valid frame with no idle cycle between them.
    build_frame(32'd500, 32'd5, 8'h42, -1, 8'h00, 8'h00);
    send_frame(10, 0);
    build_frame(32'd105, 32'd75, 8'h42, -1, 8'h00, 8'h00);
    send_frame(14, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("b2b_tick_valid", tick_valid, 1);
    check("b2b_price", tick_price, 105);
    check("b2b_qty", tick_qty, 75);
    check("b2b_is_buy", tick_is_buy, 1);
    idle(2);
    check("b2b_ok_count", pkt_ok_count, 5);
    check("b2b_drop_count", pkt_drop_count, 10);

    // Reset asserted while word 6 is on the bus, then the rest of that frame arrives.
    build_frame(32'd777, 32'd1, 8'h42, -1, 8'h00, 8'h00);
    for (int w = 0; w < 6; w++) send_word(w, 1'b0);
    send_word(6, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset_held");
    rst_n    = 1'b1;
    exp_ok   = 0;
    exp_drop = 1;   // the leftover words 7..13 form one frame that must be dropped
    exp_q.delete();
    for (int w = 7; w < 14; w++) send_word(w, w == 13);
    idle(3);
    check("midreset_drop_count", pkt_drop_count, 1);
    check("midreset_ok_count", pkt_ok_count, 0);
    check("midreset_no_tick_price", tick_price, 0);
    build_frame(32'd110, 32'd25, 8'h53, -1, 8'h00, 8'h00);
    send_frame(14, 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("midreset_tick_valid", tick_valid, 1);
    check("midreset_price", tick_price, 110);
    check("midreset_qty", tick_qty, 25);
    check("midreset_is_buy", tick_is_buy, 0);
    idle(2);
    check("midreset_ok_after", pkt_ok_count, 1);

    // Random frames against the reference model, often back to back.
    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(0, 7))
        0:       side = 8'($urandom);
        1, 2, 3: side = 8'h53;
        default: side = 8'h42;
      endcase
      bidx = ($urandom_range(0, 3) == 0) ? bad_list[$urandom_range(0, 8)] : -1;
      build_frame($urandom, $urandom, side, bidx, 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
      nw = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 16) : 14;
      send_frame(nw, ($urandom_range(0, 2) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    check("rand_ok_count", pkt_ok_count, exp_ok);
    check("rand_drop_count", pkt_drop_count, exp_drop);
    check("rand_pending_ticks", exp_q.size(), 0);
    check("rand_last_tick", {tick_is_buy, tick_price, tick_qty}, {last_buy, last_price, last_qty});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
